// File: rtl/chip8_call_ret_ctrl.sv
// chip8_call_ret_ctrl: turns CALL/RET requests into push/pop commands on the
// subroutine stack, waits out the pop read latency and returns the next PC.
// Optional build macro CHIP8_STACK_GUARD_EN: refuse CALL at full / RET at empty
// and report it; without it the depth counter wraps like the stack pointer.
module chip8_call_ret_ctrl #(
    parameter int DEPTH    = 16,
    parameter int READ_LAT = 2,
    parameter int PC_INC   = 2
) (
    input  logic                   cpu_clk,
    input  logic                   reset_n,
    input  logic                   call_req,
    input  logic                   ret_req,
    input  logic [11:0]            call_target,
    input  logic [15:0]            pc_in,
    output logic [1:0]             stk_we,
    output logic [15:0]            stk_wdata,
    input  logic [15:0]            stk_rdata,
    output logic                   pc_load,
    output logic [15:0]            pc_next,
    output logic                   done,
    output logic                   busy,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic [$clog2(DEPTH):0] depth
);
    localparam int DW = $clog2(DEPTH) + 1;
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, POP_DONE, ERR} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   wait_cnt;
    logic            full, empty, ovf_chk, unf_chk, ovf_nx, unf_nx;
    logic            load_nx, done_nx, busy_nx;
    logic [1:0]      we_nx;
    logic [DW-1:0]   depth_inc, depth_dec;

    assign full  = depth == DW'(DEPTH);
    assign empty = depth == '0;

`ifdef CHIP8_STACK_GUARD_EN
    assign ovf_chk   = call_req & full;
    assign unf_chk   = ret_req & empty;
    assign depth_inc = full ? depth : depth + DW'(1);
    assign depth_dec = empty ? depth : depth - DW'(1);
`else
    assign ovf_chk   = 1'b0;
    assign unf_chk   = 1'b0;
    assign depth_inc = full ? '0 : depth + DW'(1);
    assign depth_dec = empty ? DW'(DEPTH - 1) : depth - DW'(1);
`endif

    // State register plus registered strobes derived from the next state
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            stk_we        <= 2'b00;
            pc_load       <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state         <= state_nx;
            wait_cnt      <= (state == POP_WAIT) ? wait_cnt + CW'(1) : '0;
            stk_we        <= we_nx;
            pc_load       <= load_nx;
            done          <= done_nx;
            busy          <= busy_nx;
            err_overflow  <= ovf_nx;
            err_underflow <= unf_nx;
        end
    end

    // Next-state: simultaneous requests and guarded limits both route to ERR
    always_comb begin
        state_nx = state;
        ovf_nx   = 1'b0;
        unf_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (call_req && ret_req) state_nx = ERR;
                else if (ovf_chk) begin
                    state_nx = ERR;
                    ovf_nx   = 1'b1;
                end else if (unf_chk) begin
                    state_nx = ERR;
                    unf_nx   = 1'b1;
                end else if (call_req) state_nx = PUSH;
                else if (ret_req) state_nx = POP;
            end
            POP:      state_nx = POP_WAIT;
            POP_WAIT: state_nx = (wait_cnt == CW'(READ_LAT - 1)) ? POP_DONE : POP_WAIT;
            default:  state_nx = IDLE;
        endcase
    end

    // Output decode of the state about to be entered
    always_comb begin
        we_nx   = (state_nx == PUSH) ? 2'b01 : (state_nx == POP) ? 2'b10 : 2'b00;
        load_nx = (state_nx == PUSH) || (state_nx == POP_DONE);
        done_nx = load_nx || (state_nx == ERR);
        busy_nx = state_nx != IDLE;
    end

    // Push data, return PC capture at the end of the last wait cycle
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            stk_wdata <= '0;
            pc_next   <= '0;
        end else if (state_nx == PUSH) begin
            stk_wdata <= pc_in + 16'(PC_INC);
            pc_next   <= {4'h0, call_target};
        end else if (state_nx == POP_DONE) begin
            pc_next   <= stk_rdata;
        end
    end

    // Depth follows completed pushes and pops
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) depth <= '0;
        else if (state == PUSH) depth <= depth_inc;
        else if (state == POP_DONE) depth <= depth_dec;
    end
endmodule
